data_bus_mmio: RTL and testbench
================================

Name: data_bus_mmio

Overview:
- Data-side bus target for the single-cycle CPU; it sits directly downstream of the CPU's data address, write-data and write-enable outputs, and drives the CPU's read-data input.
- Decodes the byte address into two regions: word-addressed data RAM, and memory-mapped I/O.
- MMIO contains a UART transmitter with a TX FIFO, an LED register and a free-running cycle counter.
- Reads are combinational (the CPU has no stall); writes commit on the clock edge.

Parameters:
- DATA_ADDR_WIDTH, 16, byte-address width; bit [DATA_ADDR_WIDTH-1] selects MMIO (1) or RAM (0).
- DATA_WIDTH, 32, data word width.
- RAM_WORDS, 1024, RAM depth in words; must be a power of 2.
- FIFO_DEPTH, 4, UART TX FIFO entries; must be a power of 2.
- CLKS_PER_BIT, 434, clock cycles per UART bit; must be at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- dataAddr  in  DATA_ADDR_WIDTH  byte address from the CPU; bits [1:0] ignored.
- dataWrData  in  DATA_WIDTH  store data from the CPU.
- dataWrEnable  in  1  store strobe; sampled at the rising edge.
- dataRdData  out  DATA_WIDTH  read data to the CPU; combinational.
- led  out  8  LED register.
- uartTx  out  1  serial line, 8N1, idle high.

Behaviour:
- Reset (async, rst=1), applied immediately:
  - led=0, uartTx=1, cycle counter=0.
  - FIFO emptied, overflow flag=0, UART FSM=IDLE.
  - RAM is not cleared.
  - Reset mid-frame aborts the frame; the line is high in the same cycle.
- RAM region (addr MSB=0):
  - index = addr[log2(RAM_WORDS)+1:2]; upper bits are ignored, so addresses wrap.
  - Asynchronous read.
  - Write at the edge when dataWrEnable=1.
  - A read in the same cycle as a write returns the old word.
- MMIO region, offset = addr[7:0], upper MMIO bits ignored:
  - 0x00 TXDATA:
    - write pushes dataWrData[7:0];
    - reads 0.
  - 0x04 STATUS (read):
    - bit0 busy (FSM != IDLE);
    - bit1 full;
    - bit2 empty;
    - bit3 overflow (sticky);
    - bits[7:4] FIFO count;
    - all other bits 0.
    - Writing with bit3=1 clears overflow; other write bits are ignored.
  - 0x08 LED:
    - write loads led from dataWrData[7:0];
    - read returns led zero-extended.
  - 0x0C CYCLE:
    - reads the counter;
    - the counter increments every cycle and wraps at 2^DATA_WIDTH;
    - any write sets it to 0 at that edge (write wins over increment).
  - Any other offset: reads 0, writes ignored.
- FIFO:
  - Push accepted iff the pre-edge count < FIFO_DEPTH.
  - A push while full is dropped and sets overflow at that edge, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: count unchanged.
  - Pop on an empty FIFO is never issued.
- UART FSM, states IDLE, START, DATA, STOP; bit timer 0..CLKS_PER_BIT-1; bit index 0..7:
  - IDLE:
    - uartTx=1;
    - if FIFO is non-empty at an edge: pop into the shift register, go to START, clear the timer.
  - START: uartTx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: uartTx = shift[bitIdx], LSB first; CLKS_PER_BIT cycles per bit; after bit 7 go to STOP.
  - STOP:
    - uartTx=1 for CLKS_PER_BIT cycles;
    - at the end, if the FIFO is non-empty, pop and go directly to START (back-to-back frames); else go to IDLE.
- Latency: a TXDATA write at edge E while IDLE and the FIFO is empty:
  - the pop happens at E+1;
  - the start bit is driven from the cycle after E+1;
  - a frame is 10*CLKS_PER_BIT cycles.

Decomposition:
- Shared package holds:
  - MMIO offset constants (TXDATA/STATUS/LED/CYCLE);
  - STATUS bit-index constants;
  - the UART state enum.
- One sub-module, uart_tx: FIFO plus the serializer FSM.
  - Interface: push, pushData, clearOverflow, uartTx, busy, full, empty, overflow, count.
- The top level holds address decode, the RAM, led, the cycle counter and the read mux.

Test Plan:
1. RAM:
   - Write 0x00000040 to 0x0010, then read 0x0010 next cycle -> 0x00000040.
   - A same-cycle read returns the prior value.
   - Read 0x1010 (RAM_WORDS=1024) -> the same word (wrap).
2. UART frame, CLKS_PER_BIT=4, FIFO empty:
   - Write 0x55 to 0x8000 -> uartTx low for 4 cycles starting 2 cycles after the write edge, then 1,0,1,0,1,0,1,0 (4 cycles each), then high.
   - STATUS bit0=1 throughout the 40-cycle frame, then 0.
3. Overflow:
   - From idle, 6 consecutive TXDATA writes 0x01..0x06 -> 0x01..0x05 transmitted back-to-back; 0x06 dropped; STATUS bit3=1.
   - Write 0x8 to 0x8004 -> bit3=0.
4. Counter: write to 0x800C at edge E, then read 10 edges later -> 10; read of 0x8010 -> 0.
5. LED and reset:
   - Write 0xFFFFFFA5 to 0x8008 -> led=0xA5 after the edge; read of 0x8008 -> 0x000000A5.
   - Assert rst mid-DATA-bit -> uartTx=1, led=0 and STATUS=0x00000004 in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/data_bus_mmio_pkg.sv
// Shared constants and types for the data-side bus target: MMIO word offsets,
// STATUS bit positions and the UART serializer state encoding.
package data_bus_mmio_pkg;

  // MMIO register offsets as word indices (byte offset [7:2]).
  localparam logic [5:0] MmioTxData = 6'h00;
  localparam logic [5:0] MmioStatus = 6'h01;
  localparam logic [5:0] MmioLed    = 6'h02;
  localparam logic [5:0] MmioCycle  = 6'h03;

  localparam int unsigned StatusBusyBit  = 0;
  localparam int unsigned StatusFullBit  = 1;
  localparam int unsigned StatusEmptyBit = 2;
  localparam int unsigned StatusOvfBit   = 3;
  localparam int unsigned StatusCountLsb = 4;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/data_bus_mmio_uart_tx.sv
// UART transmitter: small TX FIFO feeding an 8N1 serializer, with a sticky
// overflow flag for pushes that arrive while the FIFO is full.
module data_bus_mmio_uart_tx
  import data_bus_mmio_pkg::*;
#(
  parameter int unsigned FifoDepth  = 4,
  parameter int unsigned ClksPerBit = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       clear_overflow_i,
  output logic       uart_tx_o,
  output logic       busy_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       overflow_o,
  output logic [3:0] count_o
);

  localparam int unsigned PtrW   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW   = $clog2(FifoDepth + 1);
  localparam int unsigned TimerW = $clog2(ClksPerBit);

  logic [7:0]        fifo_mem_q [FifoDepth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  uart_state_e       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              full, empty, push_ok, pop, timer_done;

  assign full       = (count_q == CntW'(FifoDepth));
  assign empty      = (count_q == '0);
  assign push_ok    = push_i && !full;
  assign timer_done = (timer_q == TimerW'(ClksPerBit - 1));

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop) begin
      count_d = count_q - 1'b1;
    end
    overflow_d = overflow_q;
    if (clear_overflow_i) overflow_d = 1'b0;
    // A dropped push is reported even if a clear lands on the same edge.
    if (push_i && full) overflow_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    uart_tx_o = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem_q[rd_ptr_q];
          timer_d = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        uart_tx_o = 1'b0;
        if (timer_done) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StData: begin
        uart_tx_o = shift_q[bit_idx_q];
        if (timer_done) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StStop: begin
        if (timer_done) begin
          timer_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= StIdle;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign full_o     = full;
  assign empty_o    = empty;
  assign overflow_o = overflow_q;
  assign count_o    = 4'(count_q);

endmodule

// File: rtl/data_bus_mmio.sv
// Data-side bus target for the single-cycle CPU: word RAM below the MMIO split,
// UART/LED/cycle-counter registers above it. Reads are combinational.
module data_bus_mmio
  import data_bus_mmio_pkg::*;
#(
  parameter int unsigned DATA_ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned RAM_WORDS       = 1024,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned CLKS_PER_BIT    = 434
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_ADDR_WIDTH-1:0] dataAddr,
  input  logic [DATA_WIDTH-1:0]      dataWrData,
  input  logic                       dataWrEnable,
  output logic [DATA_WIDTH-1:0]      dataRdData,
  output logic [7:0]                 led,
  output logic                       uartTx
);

  localparam int unsigned RamIdxW = $clog2(RAM_WORDS);

  logic                  is_mmio;
  logic [RamIdxW-1:0]    ram_idx;
  logic [5:0]            mmio_word;
  logic [DATA_WIDTH-1:0] ram_q [RAM_WORDS];
  logic [7:0]            led_q, led_d;
  logic [DATA_WIDTH-1:0] cycle_q, cycle_d;
  logic                  ram_we, tx_push, ovf_clear, led_we, cycle_we;
  logic                  tx_busy, tx_full, tx_empty, tx_overflow;
  logic [3:0]            tx_count;
  logic                  unused_addr;

  assign is_mmio   = dataAddr[DATA_ADDR_WIDTH-1];
  assign ram_idx   = dataAddr[RamIdxW+1:2];
  assign mmio_word = dataAddr[7:2];
  // Upper address bits and the byte lane are intentionally don't-care.
  assign unused_addr = ^dataAddr;

  always_comb begin
    ram_we    = dataWrEnable && !is_mmio;
    tx_push   = dataWrEnable && is_mmio && (mmio_word == MmioTxData);
    ovf_clear = dataWrEnable && is_mmio && (mmio_word == MmioStatus) &&
                dataWrData[StatusOvfBit];
    led_we    = dataWrEnable && is_mmio && (mmio_word == MmioLed);
    cycle_we  = dataWrEnable && is_mmio && (mmio_word == MmioCycle);
    led_d     = led_we ? dataWrData[7:0] : led_q;
    cycle_d   = cycle_we ? '0 : cycle_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= dataWrData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q   <= '0;
      cycle_q <= '0;
    end else begin
      led_q   <= led_d;
      cycle_q <= cycle_d;
    end
  end

  data_bus_mmio_uart_tx #(
    .FifoDepth  (FIFO_DEPTH),
    .ClksPerBit (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk_i            (clk),
    .rst_i            (rst),
    .push_i           (tx_push),
    .push_data_i      (dataWrData[7:0]),
    .clear_overflow_i (ovf_clear),
    .uart_tx_o        (uartTx),
    .busy_o           (tx_busy),
    .full_o           (tx_full),
    .empty_o          (tx_empty),
    .overflow_o       (tx_overflow),
    .count_o          (tx_count)
  );

  always_comb begin
    dataRdData = '0;
    if (!is_mmio) begin
      dataRdData = ram_q[ram_idx];
    end else begin
      case (mmio_word)
        MmioStatus: begin
          dataRdData[StatusBusyBit]        = tx_busy;
          dataRdData[StatusFullBit]        = tx_full;
          dataRdData[StatusEmptyBit]       = tx_empty;
          dataRdData[StatusOvfBit]         = tx_overflow;
          dataRdData[StatusCountLsb +: 4]  = tx_count;
        end
        MmioLed:   dataRdData[7:0] = led_q;
        MmioCycle: dataRdData      = cycle_q;
        default:   dataRdData      = '0;
      endcase
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_data_bus_mmio.sv
// Directed bench for data_bus_mmio with a 4-clock UART bit time.
module tb_data_bus_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dataAddr;
  logic [31:0] dataWrData;
  logic        dataWrEnable;
  logic [31:0] dataRdData;
  logic [7:0]  led;
  logic        uartTx;

  int   total = 0;
  int   bad   = 0;
  logic log_en = 1'b0;
  logic tx_log[$];

  data_bus_mmio #(
    .DATA_ADDR_WIDTH (16),
    .DATA_WIDTH      (32),
    .RAM_WORDS       (1024),
    .FIFO_DEPTH      (4),
    .CLKS_PER_BIT    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dataAddr     (dataAddr),
    .dataWrData   (dataWrData),
    .dataWrEnable (dataWrEnable),
    .dataRdData   (dataRdData),
    .led          (led),
    .uartTx       (uartTx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (log_en) tx_log.push_back(uartTx);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    dataAddr     = a;
    dataWrData   = d;
    dataWrEnable = 1'b1;
    @(posedge clk);
    #1 dataWrEnable = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [15:0] a, input logic [31:0] want);
    dataAddr = a;
    #1 check(tag, dataRdData, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] val;
    logic [7:0] rx;
    logic       exp_tx;
    logic       exp_busy;
    int         pos, prev_start, lows;

    rst          = 1'b1;
    dataAddr     = '0;
    dataWrData   = '0;
    dataWrEnable = 1'b0;
    #2;
    check("rst_tx", 32'(uartTx), 32'h1);
    check("rst_led", 32'(led), 32'h0);
    rd_check("rst_status", 16'h8004, 32'h4);
    rd_check("rst_cycle", 16'h800C, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // RAM: write, read-back, read-during-write, address wrap
    bus_write(16'h0010, 32'h0000_0040);
    rd_check("ram_rd", 16'h0010, 32'h0000_0040);
    dataWrData   = 32'h0000_0077;
    dataWrEnable = 1'b1;
    #1 check("ram_rdw_old", dataRdData, 32'h0000_0040);
    @(posedge clk);
    #1 dataWrEnable = 1'b0;
    rd_check("ram_rd_new", 16'h0010, 32'h0000_0077);
    rd_check("ram_wrap", 16'h1010, 32'h0000_0077);

    // Single frame of 0x55; k indexes the cycle after write edge E+k
    val = 8'h55;
    bus_write(16'h8000, {24'h0, val});
    dataAddr = 16'h8004;
    for (int k = 0; k <= 41; k++) begin
      @(negedge clk);
      if (k == 0)       exp_tx = 1'b1;
      else if (k <= 4)  exp_tx = 1'b0;
      else if (k <= 36) exp_tx = val[(k - 5) / 4];
      else              exp_tx = 1'b1;
      exp_busy = (k >= 1) && (k <= 40);
      check($sformatf("frame_tx k=%0d", k), 32'(uartTx), 32'(exp_tx));
      check($sformatf("frame_busy k=%0d", k), 32'(dataRdData[0]), 32'(exp_busy));
    end

    // Overflow: six pushes, one popped early, the sixth dropped
    log_en = 1'b1;
    for (int i = 1; i <= 6; i++) bus_write(16'h8000, 32'(i));
    rd_check("ovf_status", 16'h8004, 32'h0000_004B);
    bus_write(16'h8004, 32'h0000_0008);
    rd_check("ovf_cleared", 16'h8004, 32'h0000_0043);
    repeat (220) @(negedge clk);
    log_en = 1'b0;
    rd_check("drain_status", 16'h8004, 32'h0000_0004);

    pos        = 0;
    prev_start = 0;
    for (int f = 0; f < 5; f++) begin
      while (pos < tx_log.size() && tx_log[pos] != 1'b0) pos++;
      check($sformatf("frame%0d_found", f), 32'(tx_log.size() >= pos + 40), 32'h1);
      if (tx_log.size() < pos + 40) break;
      if (f > 0) check($sformatf("frame%0d_gap", f), 32'(pos - prev_start), 32'd40);
      for (int j = 0; j < 8; j++) rx[j] = tx_log[pos + 6 + 4 * j];
      check($sformatf("frame%0d_byte", f), 32'(rx), 32'(f + 1));
      check($sformatf("frame%0d_stop", f), 32'(tx_log[pos + 38]), 32'h1);
      prev_start = pos;
      pos        = pos + 40;
    end
    lows = 0;
    for (int i = pos; i < tx_log.size(); i++) if (tx_log[i] == 1'b0) lows++;
    check("no_sixth_frame", 32'(lows), 32'h0);

    // Cycle counter clear and count, unmapped offset
    bus_write(16'h800C, 32'hFFFF_FFFF);
    rd_check("cycle_clr", 16'h800C, 32'h0);
    repeat (10) @(posedge clk);
    #1 check("cycle_10", dataRdData, 32'd10);
    rd_check("unmapped", 16'h8010, 32'h0);
    rd_check("txdata_rd", 16'h8000, 32'h0);

    // LED, then asynchronous reset in the middle of a data bit
    bus_write(16'h8008, 32'hFFFF_FFA5);
    #1 check("led_out", 32'(led), 32'h0000_00A5);
    rd_check("led_rd", 16'h8008, 32'h0000_00A5);
    bus_write(16'h8000, 32'h0000_0000);
    repeat (7) @(posedge clk);
    #2 check("mid_bit_low", 32'(uartTx), 32'h0);
    dataAddr = 16'h8004;
    rst      = 1'b1;
    #1;
    check("arst_tx", 32'(uartTx), 32'h1);
    check("arst_led", 32'(led), 32'h0);
    check("arst_status", dataRdData, 32'h0000_0004);
    rd_check("arst_cycle", 16'h800C, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
